fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that sits directly upstream of the instruction memory. It generates the byte address `iaddr` each cycle and captures the 32-bit instruction word returned one cycle later. Captured words are buffered in a 2-entry queue and handed to decode over a valid/ready handshake. It also accepts branch/jump redirects from execute and flushes stale fetches.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address loaded on reset.
- `clk` in 1: single clock; the instruction memory is clocked by the same net.
- `reset` in 1: asynchronous, active-high.
- `iaddr` out 32: byte address to the instruction memory. `iaddr[11:2]` is the word index into the 1K-word memory.
- `imem_en` out 1: read enable for the instruction memory.
- `idata` in 32: instruction word, valid in the cycle after `imem_en`=1.
- `redirect` in 1: one-cycle pulse requesting a new fetch stream.
- `redirect_pc` in 32: target byte address for `redirect`.
- `inst_valid` out 1: queue head is valid.
- `inst_ready` in 1: decode accepts the head.
- `inst` out 32: head instruction word.
- `inst_pc` out 32: byte address of the head instruction.
- `align_err` out 1: sticky flag, set by a misaligned redirect.

## Operation
- State:
  - `pc`: next fetch address.
  - `inflight` bit plus `inflight_pc`.
  - 2-entry FIFO of {inst, pc}, with `count` in 0..2.
  - `align_err`.
- Pop: occurs when `inst_valid && inst_ready`.
- Issue condition (combinational): `!reset && !redirect && (count + inflight - pop) <= 1`. The queue can never overflow.
- On issue:
  - `imem_en`=1 and `iaddr`=`pc`.
  - At the clock edge: `pc` <= `pc`+4, `inflight` <= 1, `inflight_pc` <= `pc`.
  - With no issue: `imem_en`=0, `iaddr`=`pc`, and `inflight` <= 0.
- Return: when `inflight`=1, `{idata, inflight_pc}` is pushed at the edge ending that cycle. Push and pop may occur in the same cycle.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0.
- Redirect has highest priority. In the redirect cycle:
  - No issue takes place.
  - Any `idata` returning in that cycle is discarded.
  - At the edge: `count` <= 0, `inflight` <= 0, `pc` <= `{redirect_pc[31:2], 2'b00}`.
  - A pop handshake in that same cycle is still a completed transfer.
- Misaligned redirect: if `redirect_pc[1:0] != 0`, `align_err` <= 1. It stays set until reset. The fetch still proceeds at the aligned address.
- Outputs `inst`/`inst_pc` are checked only when `inst_valid`=1.

## Timing
- Reset values (asynchronous):
  - `pc`=`RESET_PC`, `count`=0, `inflight`=0, `align_err`=0.
  - `inst_valid`=0, `inst`=0, `inst_pc`=0.
  - `imem_en`=0 while `reset` is high.
  - Data returning during or just after reset is dropped.
- First cycle after reset deassertion: `imem_en`=1 and `iaddr`=`RESET_PC`.
- Latency from issue to `inst_valid` at the head is 2 cycles: issue in cycle n, data in n+1, `inst_valid` in n+2 (when the queue was empty).
- Sustained throughput with `inst_ready` held high is 1 instruction per cycle (steady state `count`=1, `inflight`=1).
- Backpressure:
  - With `inst_ready`=0, issue stops once `count + inflight` reaches 2.
  - In the cycle `inst_ready` returns high, issue resumes in that same cycle.
  - Instructions are delivered in order with no loss or duplication.
- Redirect in cycle r:
  - `iaddr`=`redirect_pc` aligned, with `imem_en`=1, in cycle r+1.
  - First new instruction has `inst_valid` in cycle r+3.
  - `inst_valid`=0 in cycles r+1 and r+2.
- Back-to-back redirects: the last one wins; each flushes again.
- Reset asserted mid-stream clears everything immediately, with no clock edge needed.

## Test plan
- Reset with `RESET_PC`=0, memory word k = 32'h1000_0000+k, `inst_ready`=1 → `iaddr` is 0, 4, 8… on consecutive cycles; `inst_valid` rises 2 cycles after the first issue; `inst` is 0x10000000, 0x10000001…, one per cycle, with `inst_pc` 0, 4, 8.
- Same stream, `inst_ready`=0 for cycles 5–8 → `imem_en` drops once `count + inflight`=2; after release the delivered sequence is contiguous and in order, with no gaps or duplicates.
- Redirect to 0x40 mid-stream → `iaddr`=0x40 in the next cycle; no old-stream `inst_pc` is delivered after the redirect cycle; the first new `inst_pc`=0x40 appears 3 cycles after the redirect.
- Redirect to 0x42 → `iaddr`=0x40, `align_err`=1 and it stays set through later aligned redirects until reset.
- `RESET_PC`=32'hFFFF_FFF8 → `iaddr` sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Assert `reset` with the queue full and `inst_ready`=0 → `inst_valid`, `inst`, `inst_pc` and `imem_en` are 0 without waiting for a clock edge; after release, fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the instruction memory, buffers returned
// words in a 2-entry queue and hands them to decode over valid/ready.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] iaddr,
    output logic        imem_en,
    input  logic [31:0] idata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        align_err
);

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } entry_t;

    logic [31:0] pc;
    logic [31:0] inflight_pc;
    logic        inflight;
    entry_t      buf_q [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  occ;

    // Handshake and issue decisions; occupancy counts the word still in
    // flight so the queue can never be overrun.
    always_comb begin
        inst_valid = (count != 2'd0);
        pop        = inst_valid && inst_ready;
        push       = inflight && !redirect;
        occ        = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
        issue      = !reset && !redirect && (occ <= 3'd1);
        imem_en    = issue;
        iaddr      = pc;
        inst       = inst_valid ? buf_q[rd_ptr].word : 32'h0;
        inst_pc    = inst_valid ? buf_q[rd_ptr].pc : 32'h0;
    end

    // Fetch pointer, in-flight tracking, queue storage and sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= 2'd0;
            align_err   <= 1'b0;
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
        end else if (redirect) begin
            pc       <= {redirect_pc[31:2], 2'b00};
            inflight <= 1'b0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
            if (redirect_pc[1:0] != 2'b00) begin
                align_err <= 1'b1;
            end
        end else begin
            inflight <= issue;
            if (issue) begin
                pc          <= pc + 32'd4;
                inflight_pc <= pc;
            end
            if (push) begin
                buf_q[wr_ptr] <= '{word: idata, pc: inflight_pc};
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: queue-based reference model checked every
// cycle, plus literal expectations at key cycles.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] iaddr, iaddr1;
    logic        imem_en, imem_en1;
    logic [31:0] idata, idata1;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_valid1;
    logic        inst_ready;
    logic [31:0] inst, inst1;
    logic [31:0] inst_pc, inst_pc1;
    logic        align_err, align_err1;

    int total = 0;
    int bad = 0;

    fetch_unit u0 (
        .clk(clk), .reset(reset), .iaddr(iaddr), .imem_en(imem_en),
        .idata(idata), .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .inst_pc(inst_pc), .align_err(align_err)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u1 (
        .clk(clk), .reset(reset), .iaddr(iaddr1), .imem_en(imem_en1),
        .idata(idata1), .redirect(1'b0), .redirect_pc(32'h0),
        .inst_valid(inst_valid1), .inst_ready(1'b1), .inst(inst1),
        .inst_pc(inst_pc1), .align_err(align_err1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memories: word k holds 0x10000000 + k, garbage when idle.
    always @(posedge clk) begin
        if (imem_en) idata <= 32'h1000_0000 + {22'b0, iaddr[11:2]};
        else         idata <= 32'hDEAD_BEEF;
        if (imem_en1) idata1 <= 32'h1000_0000 + {22'b0, iaddr1[11:2]};
        else          idata1 <= 32'hDEAD_BEEF;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: queue of buffered pcs, queue of in-flight pcs.
    logic [31:0] mq[$];
    logic [31:0] mfly[$];
    logic [31:0] mpc = 32'h0;
    logic        merr = 1'b0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        logic [31:0] t;
        t = a;
        return 32'h1000_0000 + {22'b0, t[11:2]};
    endfunction

    always @(negedge clk) begin
        int mpop, occ;
        logic [31:0] h;
        logic [31:0] rp;
        #4;
        if (reset) begin
            mq.delete();
            mfly.delete();
            mpc = 32'h0;
            merr = 1'b0;
        end
        mpop = (!reset && mq.size() > 0 && inst_ready) ? 1 : 0;
        occ = mq.size() + mfly.size() - mpop;
        chk("m_imem_en", imem_en, (!reset && !redirect && occ <= 1));
        chk("m_iaddr", iaddr, mpc);
        chk("m_valid", inst_valid, mq.size() > 0);
        chk("m_align", align_err, merr);
        if (mq.size() > 0) begin
            h = mq[0];
            chk("m_inst_pc", inst_pc, h);
            chk("m_inst", inst, word_of(h));
        end
        if (!reset) begin
            if (mpop == 1) void'(mq.pop_front());
            if (redirect) begin
                mq.delete();
                mfly.delete();
                rp = redirect_pc;
                mpc = {rp[31:2], 2'b00};
                if (rp[1:0] != 2'b00) merr = 1'b1;
            end else begin
                if (mfly.size() > 0) mq.push_back(mfly.pop_front());
                if (occ <= 1) begin
                    mfly.push_back(mpc);
                    mpc = mpc + 32'd4;
                end
            end
        end
    end

    task automatic adv();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        inst_ready = 1'b1;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        repeat (3) adv();
        #4;
        chk("rst_en", imem_en, 0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_inst", inst, 0);
        // cycle 0
        adv(); reset = 1'b0; #4;
        chk("c0_iaddr", iaddr, 32'h0);
        chk("c0_en", imem_en, 1);
        chk("c0_u1", iaddr1, 32'hFFFF_FFF8);
        adv(); #4;
        chk("c1_iaddr", iaddr, 32'h4);
        chk("c1_valid", inst_valid, 0);
        chk("c1_u1", iaddr1, 32'hFFFF_FFFC);
        adv(); #4;
        chk("c2_valid", inst_valid, 1);
        chk("c2_inst", inst, 32'h1000_0000);
        chk("c2_pc", inst_pc, 32'h0);
        chk("c2_u1", iaddr1, 32'h0);
        adv(); #4;
        chk("c3_inst", inst, 32'h1000_0001);
        chk("c3_pc", inst_pc, 32'h4);
        chk("c3_u1", iaddr1, 32'h4);
        adv();
        // backpressure cycles 5-8
        adv(); inst_ready = 1'b0; #4;
        chk("c5_en", imem_en, 0);
        chk("c5_pc", inst_pc, 32'hC);
        repeat (3) adv();
        adv(); inst_ready = 1'b1; #4;
        chk("c9_en", imem_en, 1);
        chk("c9_pc", inst_pc, 32'hC);
        adv(); #4;
        chk("c10_pc", inst_pc, 32'h10);
        repeat (3) adv();
        // redirect to 0x40 at cycle 14
        adv(); redirect = 1'b1; redirect_pc = 32'h40; #4;
        chk("c14_en", imem_en, 0);
        adv(); redirect = 1'b0; #4;
        chk("c15_iaddr", iaddr, 32'h40);
        chk("c15_en", imem_en, 1);
        chk("c15_valid", inst_valid, 0);
        adv(); #4;
        chk("c16_valid", inst_valid, 0);
        adv(); #4;
        chk("c17_valid", inst_valid, 1);
        chk("c17_pc", inst_pc, 32'h40);
        chk("c17_inst", inst, 32'h1000_0010);
        repeat (2) adv();
        // misaligned redirect at cycle 20
        adv(); redirect = 1'b1; redirect_pc = 32'h42;
        adv(); redirect = 1'b0; #4;
        chk("c21_iaddr", iaddr, 32'h40);
        chk("c21_align", align_err, 1);
        repeat (2) adv();
        adv(); redirect = 1'b1; redirect_pc = 32'h80;
        adv(); redirect = 1'b0;
        adv(); #4;
        chk("c26_align", align_err, 1);
        adv();
        // back-to-back redirects at cycles 28, 29
        adv(); redirect = 1'b1; redirect_pc = 32'h100;
        adv(); redirect_pc = 32'h200;
        adv(); redirect = 1'b0; #4;
        chk("c30_iaddr", iaddr, 32'h200);
        adv();
        adv(); #4;
        chk("c32_valid", inst_valid, 1);
        chk("c32_pc", inst_pc, 32'h200);
        repeat (3) adv();
        // fill the queue, then reset mid-cycle
        adv(); inst_ready = 1'b0;
        repeat (3) adv();
        #4;
        chk("c39_valid", inst_valid, 1);
        chk("c39_en", imem_en, 0);
        adv(); #1 reset = 1'b1; #3;
        chk("ar_valid", inst_valid, 0);
        chk("ar_inst", inst, 0);
        chk("ar_pc", inst_pc, 0);
        chk("ar_en", imem_en, 0);
        chk("ar_align", align_err, 0);
        adv(); reset = 1'b0; inst_ready = 1'b1; #4;
        chk("rr_iaddr", iaddr, 32'h0);
        chk("rr_en", imem_en, 1);
        repeat (6) adv();
        #4;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
